alu_exec_stage: RTL and testbench

- Sequential issue/retire wrapper around the 16-bit combinational ALU (5-bit opcode, x/y operands; outputs r, N/Z/C/V flags and the division-invalid flag).
- Accepts one operation per valid/ready handshake and holds operands stable on the ALU inputs for an opcode-dependent settle time.
- Registers the result and owns the architectural CPSR flag register.
- Presents the retired result downstream through a second valid/ready handshake.

---
 rtl/alu_exec_stage.sv | 180 ++++++++++++++++++
 tb/tb_alu_exec_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: issue/retire wrapper around the 16-bit combinational ALU.
// Holds operands on the ALU for an opcode-dependent settle time, registers
// the result and owns the CPSR flag register.
// Optional feature macro: ALU_EXEC_STICKY_ERR_EN (sticky fault flag).
module alu_exec_stage #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned SHORT_LAT = 1,
  parameter int unsigned LONG_LAT  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_opcode,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_setflags,
  output logic [4:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             alu_div_invalid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic             out_wb,
  output logic             out_fault,
  output logic [3:0]       cpsr,
  output logic             err_sticky,
  input  logic             err_clr
);

  localparam int unsigned MAX_LAT = (LONG_LAT > SHORT_LAT) ? LONG_LAT : SHORT_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_ready_q;
  logic [4:0]         opcode_q;
  logic [WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]   y_q;
  logic               setflags_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_r_q;
  logic               out_wb_q;
  logic               out_fault_q;
  logic [3:0]         cpsr_q;

  logic [CNT_W-1:0]   cnt_load_d;
  logic               capture_d;
  logic [WIDTH-1:0]   cap_r_d;
  logic               cap_wb_d;
  logic               cap_fault_d;
  logic [3:0]         cap_cpsr_d;

  // Settle-time selection for the incoming opcode (mul, div/mod, fp add/sub are long)
  always_comb begin
    cnt_load_d = CNT_W'(SHORT_LAT - 1);
    case (in_opcode)
      5'b00011, 5'b00100, 5'b01101, 5'b01110,
      5'b01111, 5'b10000, 5'b10001, 5'b10010: cnt_load_d = CNT_W'(LONG_LAT - 1);
      default: cnt_load_d = CNT_W'(SHORT_LAT - 1);
    endcase
  end

  // Retire classification: illegal, divide fault, compare, or normal writeback
  always_comb begin
    capture_d   = (state_q == EXEC) && (cnt_q == '0);
    cap_r_d     = alu_r;
    cap_wb_d    = 1'b1;
    cap_fault_d = 1'b0;
    cap_cpsr_d  = setflags_q ? {alu_n, alu_z, alu_c, alu_v} : cpsr_q;
    if (!((opcode_q <= 5'd18) || ((opcode_q >= 5'd24) && (opcode_q <= 5'd28)) ||
          (opcode_q == 5'd30))) begin
      cap_r_d     = '0;
      cap_wb_d    = 1'b0;
      cap_fault_d = 1'b1;
      cap_cpsr_d  = cpsr_q;
    end else if ((opcode_q == 5'b01101) && alu_div_invalid) begin
      cap_wb_d    = 1'b0;
      cap_fault_d = 1'b1;
      cap_cpsr_d  = cpsr_q;
    end else if ((opcode_q == 5'b00101) || (opcode_q == 5'b11110)) begin
      cap_r_d     = '0;
      cap_wb_d    = 1'b0;
    end
  end

  // Issue/execute/retire FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      opcode_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      setflags_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_wb_q    <= 1'b0;
      out_fault_q <= 1'b0;
      cpsr_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            opcode_q   <= in_opcode;
            x_q        <= in_x;
            y_q        <= in_y;
            setflags_q <= in_setflags;
            cnt_q      <= cnt_load_d;
            in_ready_q <= 1'b0;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            out_r_q     <= cap_r_d;
            out_wb_q    <= cap_wb_d;
            out_fault_q <= cap_fault_d;
            cpsr_q      <= cap_cpsr_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_EXEC_STICKY_ERR_EN
  logic err_q;

  // Sticky fault flag: set on a faulting capture, set wins over clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (capture_d && cap_fault_d) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign err_sticky = err_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign err_sticky     = 1'b0;
`endif

  assign in_ready   = in_ready_q;
  assign alu_opcode = opcode_q;
  assign alu_x      = x_q;
  assign alu_y      = y_q;
  assign out_valid  = out_valid_q;
  assign out_r      = out_r_q;
  assign out_wb     = out_wb_q;
  assign out_fault  = out_fault_q;
  assign cpsr       = cpsr_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed vector table, reset
// corner cases, then randomized ops against a rule-level reference model.
module tb_alu_exec_stage;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned SHORT_LAT = 1;
  localparam int unsigned LONG_LAT  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [4:0]       in_opcode = '0;
  logic [WIDTH-1:0] in_x = '0;
  logic [WIDTH-1:0] in_y = '0;
  logic             in_setflags = 1'b0;
  logic [4:0]       alu_opcode;
  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] alu_r = '0;
  logic             alu_n = 1'b0;
  logic             alu_z = 1'b0;
  logic             alu_c = 1'b0;
  logic             alu_v = 1'b0;
  logic             alu_div_invalid = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_r;
  logic             out_wb;
  logic             out_fault;
  logic [3:0]       cpsr;
  logic             err_sticky;
  logic             err_clr = 1'b0;

  alu_exec_stage #(.WIDTH(WIDTH), .SHORT_LAT(SHORT_LAT), .LONG_LAT(LONG_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_x(in_x), .in_y(in_y), .in_setflags(in_setflags),
    .alu_opcode(alu_opcode), .alu_x(alu_x), .alu_y(alu_y),
    .alu_r(alu_r), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .alu_div_invalid(alu_div_invalid),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .out_wb(out_wb), .out_fault(out_fault), .cpsr(cpsr),
    .err_sticky(err_sticky), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [3:0] cpsr_m = 4'b0000;
  logic       err_m  = 1'b0;

  typedef struct {
    logic [4:0]  opc;
    logic [15:0] x;
    logic [15:0] y;
    logic        sf;
    logic [15:0] r;
    logic [3:0]  f;
    logic        dv;
    int          delay;
    logic        clr;
    logic [15:0] er;
    logic        ewb;
    logic        ef;
    logic [3:0]  ecp;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int lat_of(input logic [4:0] opc);
    int long_ops[8] = '{3, 4, 13, 14, 15, 16, 17, 18};
    foreach (long_ops[i]) if (int'(opc) == long_ops[i]) return LONG_LAT;
    return SHORT_LAT;
  endfunction

  // Reference model: retire outcome from the opcode rules
  task automatic model(input logic [4:0] opc, input logic sf, input logic [15:0] r,
                       input logic [3:0] f, input logic dv, input logic [3:0] cp_in,
                       output logic [15:0] er, output logic ewb, output logic ef,
                       output logic [3:0] ecp);
    int o = int'(opc);
    bit legal = (o <= 18) || (o >= 24 && o <= 28) || (o == 30);
    if (!legal) begin
      er = 16'h0; ewb = 1'b0; ef = 1'b1; ecp = cp_in;
    end else if (o == 13 && dv) begin
      er = r; ewb = 1'b0; ef = 1'b1; ecp = cp_in;
    end else if (o == 5 || o == 30) begin
      er = 16'h0; ewb = 1'b0; ef = 1'b0; ecp = sf ? f : cp_in;
    end else begin
      er = r; ewb = 1'b1; ef = 1'b0; ecp = sf ? f : cp_in;
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int k;
    int lat;
    bit got;
    bit hold_ok;
    k = 0;
    while (!in_ready && k < 20) begin @(posedge clk); #1; k++; end
    chk({tag, " ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b1; in_opcode = v.opc; in_x = v.x; in_y = v.y; in_setflags = v.sf;
    alu_r = v.r; {alu_n, alu_z, alu_c, alu_v} = v.f; alu_div_invalid = v.dv;
    if (v.clr) err_clr = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_x = ~v.x; in_y = ~v.y; in_opcode = ~v.opc;
    chk({tag, " latch"}, {27'd0, in_ready, alu_opcode, alu_x, alu_y},
        {27'd0, 1'b0, v.opc, v.x, v.y});
    lat = lat_of(v.opc);
    got = 0;
    for (k = 1; k <= lat + 10; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin got = 1; break; end
    end
    chk({tag, " latency"}, got ? 64'(k) : 64'hFFFF, 64'(lat));
`ifdef ALU_EXEC_STICKY_ERR_EN
    if (v.ef) err_m = 1'b1;
`else
    err_m = 1'b0;
`endif
    cpsr_m = v.ecp;
    chk({tag, " result"}, {40'd0, out_r, out_wb, out_fault, cpsr, err_sticky},
        {40'd0, v.er, v.ewb, v.ef, v.ecp, err_m});
    err_clr = 1'b0;
    hold_ok = 1;
    repeat (v.delay) begin
      @(posedge clk); #1;
      if (!out_valid || out_r !== v.er || in_ready || cpsr !== v.ecp) hold_ok = 0;
    end
    if (v.delay > 0) chk({tag, " hold"}, 64'(hold_ok), 64'd1);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({tag, " release"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  task automatic clr_test();
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    err_m = 1'b0;
    chk("err_clr", 64'(err_sticky), 64'(err_m));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, {18'd0, in_ready, out_valid, out_r, out_wb, out_fault, cpsr, err_sticky,
              alu_opcode, alu_x},
        64'd0);
    chk({tag, " y"}, 64'(alu_y), 64'd0);
  endtask

  initial begin
    vec_t v;
    bit seen;
    // opc, x, y, sf, r, nzcv, dv, delay, clr, exp r, exp wb, exp fault, exp cpsr
    tbl[0]  = '{5'b00001, 16'd3,   16'd4, 1'b1, 16'h0007, 4'b0000, 1'b0, 0, 1'b0, 16'h0007, 1'b1, 1'b0, 4'b0000};
    tbl[1]  = '{5'b01101, 16'd100, 16'd7, 1'b0, 16'd14,   4'b0000, 1'b0, 3, 1'b0, 16'd14,   1'b1, 1'b0, 4'b0000};
    tbl[2]  = '{5'b00000, 16'h1,   16'h2, 1'b1, 16'h8000, 4'b1000, 1'b0, 0, 1'b0, 16'h8000, 1'b1, 1'b0, 4'b1000};
    tbl[3]  = '{5'b01101, 16'd50,  16'd0, 1'b1, 16'hFFFF, 4'b0110, 1'b1, 1, 1'b0, 16'hFFFF, 1'b0, 1'b1, 4'b1000};
    tbl[4]  = '{5'b11110, 16'h5,   16'h5, 1'b1, 16'h1234, 4'b0100, 1'b0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0100};
    tbl[5]  = '{5'b11110, 16'h5,   16'h9, 1'b0, 16'h1234, 4'b1111, 1'b0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0100};
    tbl[6]  = '{5'b11111, 16'hAA,  16'hBB,1'b1, 16'h5555, 4'b1111, 1'b0, 2, 1'b1, 16'h0000, 1'b0, 1'b1, 4'b0100};
    tbl[7]  = '{5'b00101, 16'h1,   16'h2, 1'b1, 16'h4444, 4'b0011, 1'b0, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0011};
    tbl[8]  = '{5'b10100, 16'h7,   16'h8, 1'b1, 16'h6666, 4'b1100, 1'b0, 0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'b0011};
    tbl[9]  = '{5'b11100, 16'h9,   16'hA, 1'b1, 16'h00AA, 4'b0001, 1'b0, 0, 1'b0, 16'h00AA, 1'b1, 1'b0, 4'b0001};
    tbl[10] = '{5'b10010, 16'hB,   16'hC, 1'b1, 16'h0BAD, 4'b1010, 1'b0, 1, 1'b0, 16'h0BAD, 1'b1, 1'b0, 4'b1010};
    tbl[11] = '{5'b11101, 16'hD,   16'hE, 1'b0, 16'h7777, 4'b0101, 1'b1, 0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'b1010};

    // Power-on reset and release
    #12;
    chk_reset_vals("reset");
    @(negedge clk); rst_n = 1'b1; #1;
    chk("ready low before edge", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("ready after release", 64'(in_ready), 64'd1);

    foreach (tbl[i]) begin
      run_op(tbl[i], $sformatf("vec%0d", i));
      if (i == 6) clr_test();
    end

    // Reset two cycles into a long op: aborted, nothing retires
    v = '{5'b00011, 16'h11, 16'h22, 1'b1, 16'h3333, 4'b1111, 1'b0, 0, 1'b0, 16'h0, 1'b0, 1'b0, 4'b0};
    @(negedge clk);
    in_valid = 1'b1; in_opcode = v.opc; in_x = v.x; in_y = v.y; in_setflags = v.sf;
    alu_r = v.r; {alu_n, alu_z, alu_c, alu_v} = v.f; alu_div_invalid = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0; #1;
    cpsr_m = 4'b0000; err_m = 1'b0;
    chk_reset_vals("mid-exec reset");
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    chk("no retire after abort", {62'd0, seen, in_ready}, 64'b01);
    chk("cpsr after abort", 64'(cpsr), 64'(cpsr_m));

    // Randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      v.opc = 5'($urandom_range(0, 31));
      v.x = 16'($urandom); v.y = 16'($urandom); v.r = 16'($urandom);
      v.sf = 1'($urandom); v.f = 4'($urandom); v.dv = 1'($urandom);
      v.delay = $urandom_range(0, 2); v.clr = 1'b0;
      model(v.opc, v.sf, v.r, v.f, v.dv, cpsr_m, v.er, v.ewb, v.ef, v.ecp);
      run_op(v, $sformatf("rnd%0d op%0d", n, v.opc));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
